// File: rtl/pos_cmd_reader_if.sv
// Command-side handshake between the motor control logic and pos_cmd_reader.
// master = motor control (issues moves), slave = pos_cmd_reader.
interface pos_cmd_reader_if #(
    parameter int unsigned CNT_W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [CNT_W-1:0] cmd_dist;
    logic             abort;
    logic             motor_en;
    logic             move_done;

    modport master (
        output cmd_valid, cmd_dist, abort,
        input  cmd_ready, motor_en, move_done
    );

    modport slave (
        input  cmd_valid, cmd_dist, abort,
        output cmd_ready, motor_en, move_done
    );
endinterface

// File: rtl/pos_cmd_reader.sv
// Consumer of the encoder position counter: periodic speed sampling on pos1 and a
// move-by-distance FSM on pos2. Optional macro SPEED_AVG_EN averages the last 4 speed samples.
module pos_cmd_reader #(
    parameter int unsigned SAMPLE_CYCLES = 100000,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] pos1,
    input  logic [CNT_W-1:0] pos2,
    output logic [1:0]       clear,
    output logic             subtract,
    output logic [CNT_W-1:0] distance,
    output logic [CNT_W-1:0] speed,
    output logic             speed_valid,
    pos_cmd_reader_if.slave  cmd
);

    localparam int unsigned      WIN_W    = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(SAMPLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_SUB    = 2'd2,
        S_SETTLE = 2'd3
    } state_e;

    logic [WIN_W-1:0] win_q, win_d;
    logic             win_tc;
    logic             sample_q, sample_d;
    logic [CNT_W-1:0] speed_q, speed_d, speed_new;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] dist_q, dist_d;
    logic             done_q, done_d;
    logic             clr_pos2_q, clr_pos2_d;
    logic             sub_fire;

    // ------------------------------------------------------------------
    // Speed window
    // ------------------------------------------------------------------
    assign win_tc = (win_q == WIN_LAST);

`ifdef SPEED_AVG_EN
    logic [2:0][CNT_W-1:0] hist_q, hist_d;
    logic [CNT_W+1:0]      avg_sum;

    always_comb begin
        avg_sum   = {2'b00, pos1} + {2'b00, hist_q[0]} + {2'b00, hist_q[1]} + {2'b00, hist_q[2]};
        speed_new = avg_sum[CNT_W+1:2];
        hist_d    = win_tc ? {hist_q[1:0], pos1} : hist_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hist_q <= '0;
        else        hist_q <= hist_d;
    end
`else
    assign speed_new = pos1;
`endif

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        win_d    = win_tc ? '0 : win_q + 1'b1;
        sample_d = win_tc;
        speed_d  = win_tc ? speed_new : speed_q;
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q    <= '0;
            sample_q <= 1'b0;
            speed_q  <= '0;
        end else begin
            win_q    <= win_d;
            sample_q <= sample_d;
            speed_q  <= speed_d;
        end
    end

    // ------------------------------------------------------------------
    // Move FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            dist_q     <= '0;
            done_q     <= 1'b0;
            clr_pos2_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dist_q     <= dist_d;
            done_q     <= done_d;
            clr_pos2_q <= clr_pos2_d;
        end
    end

    // Move FSM: next state. Abort overrides whatever the case statement chose.
    always_comb begin
        state_d    = state_q;
        dist_d     = dist_q;
        done_d     = 1'b0;
        clr_pos2_d = cmd.abort;

        unique case (state_q)
            S_IDLE: begin
                if (cmd.cmd_valid && !cmd.abort) begin
                    dist_d = cmd.cmd_dist;
                    if (cmd.cmd_dist == '0) done_d  = 1'b1;
                    else                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (pos2 >= dist_q) state_d = S_SUB;
            end
            S_SUB: begin
                if (sub_fire) state_d = S_SETTLE;
            end
            S_SETTLE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (cmd.abort) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
        end
    end

    // Move FSM: outputs. The counter ignores subtract while any clear is active,
    // so the subtract is held off until both clear lines are low.
    always_comb begin
        cmd.cmd_ready = 1'b0;
        cmd.motor_en  = 1'b0;
        sub_fire      = 1'b0;
        unique case (state_q)
            S_IDLE:  cmd.cmd_ready = !cmd.abort;
            S_RUN:   cmd.motor_en  = !cmd.abort;
            S_SUB:   sub_fire      = !cmd.abort && !sample_q && !clr_pos2_q;
            default: ;
        endcase
    end

    assign cmd.move_done = done_q;
    assign clear         = {clr_pos2_q, sample_q};
    assign subtract      = sub_fire;
    assign distance      = sub_fire ? dist_q : '0;
    assign speed         = speed_q;
    assign speed_valid   = sample_q;

endmodule

// File: tb/tb_pos_cmd_reader.sv
// Directed bench for pos_cmd_reader (SAMPLE_CYCLES=20); a negedge monitor scoreboards
// speed samples, subtract requests and move_done pulses against queued expectations.
module tb_pos_cmd_reader;

    localparam int CNT_W = 16;
    localparam int SC    = 20;

    logic             clk;
    logic             rst_n;
    logic [CNT_W-1:0] pos1;
    logic [CNT_W-1:0] pos2;
    logic [1:0]       clear;
    logic             subtract;
    logic [CNT_W-1:0] distance;
    logic [CNT_W-1:0] speed;
    logic             speed_valid;

    pos_cmd_reader_if #(.CNT_W(CNT_W)) cmd_if ();

    pos_cmd_reader #(.SAMPLE_CYCLES(SC), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pos1        (pos1),
        .pos2        (pos2),
        .clear       (clear),
        .subtract    (subtract),
        .distance    (distance),
        .speed       (speed),
        .speed_valid (speed_valid),
        .cmd         (cmd_if)
    );

    int checks = 0;
    int errors = 0;

    logic [CNT_W-1:0] exp_speed_q[$];
    logic [CNT_W-1:0] exp_dist_q[$];
    int               exp_done_q[$];
    int               m_win;
`ifdef SPEED_AVG_EN
    int               m_hist[3];
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    task automatic wait_sv(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!speed_valid && n < SC + 5);
        check("speed_valid_seen", speed_valid, 1);
    endtask

    // Scoreboard monitor plus a window model that queues each expected speed sample
    always @(negedge clk) begin
        if (!rst_n) begin
            m_win = 0;
            exp_speed_q.delete();
`ifdef SPEED_AVG_EN
            for (int i = 0; i < 3; i++) m_hist[i] = 0;
`endif
        end else begin
            if (speed_valid) begin
                check("speed_pending", exp_speed_q.size() > 0, 1);
                if (exp_speed_q.size() > 0) check("speed_value", speed, exp_speed_q.pop_front());
                check("speed_with_clear0", clear[0], 1);
            end
            if (subtract) begin
                check("sub_pending", exp_dist_q.size() > 0, 1);
                if (exp_dist_q.size() > 0) check("sub_distance", distance, exp_dist_q.pop_front());
                check("sub_without_clear", clear, 2'b00);
            end
            if (cmd_if.move_done) begin
                check("done_pending", exp_done_q.size() > 0, 1);
                if (exp_done_q.size() > 0) void'(exp_done_q.pop_front());
            end
            if (m_win == SC - 1) begin
`ifdef SPEED_AVG_EN
                int sum;
                sum = int'(pos1) + m_hist[0] + m_hist[1] + m_hist[2];
                exp_speed_q.push_back(CNT_W'(sum >> 2));
                m_hist[2] = m_hist[1];
                m_hist[1] = m_hist[0];
                m_hist[0] = int'(pos1);
`else
                exp_speed_q.push_back(pos1);
`endif
                m_win = 0;
            end else begin
                m_win++;
            end
        end
    end

    initial begin
        int n;
`ifdef SPEED_AVG_EN
        int avg_in[4]  = '{4, 8, 12, 16};
        int avg_out[4] = '{1, 3, 6, 10};
`endif
        rst_n            = 1'b0;
        pos1             = '0;
        pos2             = '0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_dist  = '0;
        cmd_if.abort     = 1'b0;

        // Reset state
        look(); look();
        check("rst_clear", clear, 2'b00);
        check("rst_subtract", subtract, 0);
        check("rst_distance", distance, 0);
        check("rst_cmd_ready", cmd_if.cmd_ready, 1);
        check("rst_motor_en", cmd_if.motor_en, 0);
        check("rst_move_done", cmd_if.move_done, 0);
        check("rst_speed", speed, 0);
        check("rst_speed_valid", speed_valid, 0);

        tick();
        rst_n = 1'b1;
`ifdef SPEED_AVG_EN
        pos1 = CNT_W'(avg_in[0]);
`else
        pos1 = 16'd7;
`endif
        look();
        check("post_rst_cmd_ready", cmd_if.cmd_ready, 1);
        check("post_rst_motor_en", cmd_if.motor_en, 0);
        check("post_rst_clear", clear, 2'b00);

`ifdef SPEED_AVG_EN
        // Averaged speed ramps up from a zeroed history
        for (int i = 0; i < 4; i++) begin
            wait_sv(n);
            check("avg_speed", speed, avg_out[i]);
            tick();
            pos1 = (i < 3) ? CNT_W'(avg_in[i+1]) : 16'd7;
        end
        repeat (4) wait_sv(n);
`endif

        // Speed window: period, clear[0] alongside speed_valid, single-cycle pulses
        wait_sv(n);
        wait_sv(n);
        check("speed_period", n, SC);
        check("speed_clear_pulse", clear, 2'b01);
        check("speed_hold_value", speed, 7);
        look();
        check("speed_valid_one_cycle", speed_valid, 0);
        check("clear_one_cycle", clear, 2'b00);
        check("speed_holds", speed, 7);

        // Normal move of 10 edges with pos2 ramping to 12
        tick();
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_dist  = 16'd10;
        pos2             = '0;
        look();
        check("move_cmd_ready", cmd_if.cmd_ready, 1);
        check("move_motor_idle", cmd_if.motor_en, 0);
        tick();
        cmd_if.cmd_valid = 1'b0;
        pos2             = 16'd2;
        look();
        check("move_motor_on", cmd_if.motor_en, 1);
        check("move_not_ready", cmd_if.cmd_ready, 0);
        for (int v = 4; v <= 8; v += 2) begin
            tick();
            pos2 = CNT_W'(v);
        end
        tick();
        pos2 = 16'd10;
        exp_dist_q.push_back(16'd10);
        look();
        check("move_no_early_sub", subtract, 0);
        check("move_motor_still_on", cmd_if.motor_en, 1);
        tick();
        pos2 = 16'd12;
        exp_done_q.push_back(1);
        look();
        check("move_subtract", subtract, 1);
        check("move_distance", distance, 10);
        check("move_motor_off", cmd_if.motor_en, 0);
        tick();
        pos2 = 16'd2;
        look();
        check("move_single_sub", subtract, 0);
        check("move_distance_zero", distance, 0);
        check("move_done_not_yet", cmd_if.move_done, 0);
        tick();
        look();
        check("move_done_pulse", cmd_if.move_done, 1);
        check("move_motor_after", cmd_if.motor_en, 0);
        tick();
        look();
        check("move_done_one_cycle", cmd_if.move_done, 0);
        check("move_back_idle", cmd_if.cmd_ready, 1);

        // Collision: SUB lands on the clear[0] cycle, subtract slips by one cycle
        wait_sv(n);
        tick();
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_dist  = 16'd5;
        pos2             = '0;
        tick();
        cmd_if.cmd_valid = 1'b0;
        repeat (16) tick();
        look();
        check("coll_running", cmd_if.motor_en, 1);
        tick();
        pos2 = 16'd5;
        exp_dist_q.push_back(16'd5);
        look();
        check("coll_no_sub_yet", subtract, 0);
        tick();
        look();
        check("coll_clear0", clear, 2'b01);
        check("coll_sub_deferred", subtract, 0);
        check("coll_distance_zero", distance, 0);
        tick();
        pos2 = '0;
        exp_done_q.push_back(1);
        look();
        check("coll_sub_retry", subtract, 1);
        check("coll_distance", distance, 5);
        check("coll_clear_low", clear, 2'b00);
        tick();
        look();
        check("coll_single_sub", subtract, 0);
        tick();
        look();
        check("coll_done", cmd_if.move_done, 1);

        // Zero-distance command
        tick();
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_dist  = '0;
        exp_done_q.push_back(1);
        look();
        check("zero_cmd_ready", cmd_if.cmd_ready, 1);
        tick();
        cmd_if.cmd_valid = 1'b0;
        look();
        check("zero_done", cmd_if.move_done, 1);
        check("zero_motor_off", cmd_if.motor_en, 0);
        check("zero_no_sub", subtract, 0);
        tick();
        look();
        check("zero_done_one_cycle", cmd_if.move_done, 0);
        check("zero_idle", cmd_if.cmd_ready, 1);

        // Abort during RUN
        tick();
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_dist  = 16'd50;
        pos2             = '0;
        tick();
        cmd_if.cmd_valid = 1'b0;
        pos2             = 16'd20;
        look();
        check("abort_running", cmd_if.motor_en, 1);
        tick();
        cmd_if.abort = 1'b1;
        look();
        check("abort_motor_off", cmd_if.motor_en, 0);
        tick();
        cmd_if.abort = 1'b0;
        look();
        check("abort_clear_pos2", clear, 2'b10);
        check("abort_cmd_ready", cmd_if.cmd_ready, 1);
        check("abort_motor_stays_off", cmd_if.motor_en, 0);
        tick();
        look();
        check("abort_clear_one_cycle", clear, 2'b00);
        check("abort_no_done", cmd_if.move_done, 0);
        check("abort_no_sub", subtract, 0);

        // Asynchronous reset in the middle of a move
        tick();
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_dist  = 16'd30;
        pos2             = '0;
        tick();
        cmd_if.cmd_valid = 1'b0;
        look();
        check("rst_mid_running", cmd_if.motor_en, 1);
        tick();
        rst_n = 1'b0;
        #1;
        check("rst_mid_motor_off", cmd_if.motor_en, 0);
        check("rst_mid_idle", cmd_if.cmd_ready, 1);
        look();
        tick();
        rst_n = 1'b1;
        look();
        check("rst_mid_after_motor", cmd_if.motor_en, 0);
        check("rst_mid_after_ready", cmd_if.cmd_ready, 1);

        // Window restarts cleanly after reset
        wait_sv(n);
        check("rst_window_period", n, SC);

        check("dist_queue_drained", exp_dist_q.size(), 0);
        check("done_queue_drained", exp_done_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pos_cmd_reader.md
Name: pos_cmd_reader

Overview:
- Consumer side of the encoder position counter. Reads the counter's pos1/pos2 and drives its clear/subtract/distance inputs.
- Produces a periodic speed sample from pos1 by latching it and then clearing it.
- Runs a move-by-distance FSM on pos2. When a move completes, the target distance is subtracted from pos2 so that overshoot carries into the next move.
- Sits between the motor PWM/control logic and the position counter, one instance per wheel.

Parameters:
- SAMPLE_CYCLES, 100000, clocks per speed-sample window (≥4).
- CNT_W, 16, width of pos/distance/speed paths (must match counter).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pos1  in  CNT_W  counter value for speed (edges since last clear[0])
- pos2  in  CNT_W  counter value for position (unsigned)
- clear  out  2  clear[0] clears pos1, clear[1] clears pos2
- subtract  out  1  one-cycle request to reduce pos2 by distance
- distance  out  CNT_W  subtract amount; valid whenever subtract=1
- cmd_valid  in  1  move command offered
- cmd_ready  out  1  high only in IDLE
- cmd_dist  in  CNT_W  edges to travel, captured on cmd_valid&cmd_ready
- abort  in  1  cancel move and clear pos2
- motor_en  out  1  high while a move is running
- move_done  out  1  one-cycle pulse on move completion
- speed  out  CNT_W  last latched speed sample
- speed_valid  out  1  one-cycle pulse when speed updates

Behaviour:
Reset (rst_n low, asynchronous):
- All outputs are 0 except cmd_ready=1.
- Window counter is 0 and the FSM is in IDLE.

Speed window:
- The window counter counts 0..SAMPLE_CYCLES-1 and wraps.
- On the terminal count: speed<=pos1, and speed_valid=1 plus clear[0]=1 in the following cycle (one cycle each).
- Edges arriving during the clear[0] cycle are lost because the counter gives clear priority. This is accepted.

Move FSM states:
- IDLE: cmd_ready=1.
  - On cmd_valid, capture cmd_dist into dist_r.
  - If dist_r==0: pulse move_done next cycle, stay IDLE, no subtract.
  - Otherwise go to RUN.
- RUN: motor_en=1. When pos2 ≥ dist_r (unsigned), go to SUB.
- SUB: assert subtract=1 and distance=dist_r for exactly one cycle, then go to SETTLE.
  - Defer rule: if clear[0] or clear[1] is being asserted this cycle, hold subtract low and retry next cycle, because the counter ignores subtract while any clear is active.
- SETTLE: one cycle so pos2 reflects the subtraction. Pulse move_done and return to IDLE.

Abort:
- abort in RUN/SUB/SETTLE: assert clear[1] one cycle, motor_en=0, return to IDLE, no move_done, no subtract.
- abort in IDLE: assert clear[1] only.
- abort has priority over every FSM transition in the same cycle.

Outputs and latency:
- distance reads 0 when subtract=0.
- motor_en drops the cycle after RUN exits.
- Latency from pos2 reaching dist_r to the move_done pulse is 3 cycles (RUN compare, SUB, SETTLE); deferral adds 1 cycle per blocked cycle.

Overflow:
- The FSM never adds to pos2. Wrap beyond 2^CNT_W-1 is the counter's behaviour and is not detected here.

Optional Feature:
SPEED_AVG_EN
- Defined: speed is the mean of the last 4 raw samples. A CNT_W+2 sum is shifted right by 2, truncating.
  - The history resets to 0, so the first 3 outputs ramp.
  - speed_valid timing is unchanged.
- Undefined: speed is the raw pos1 latch.

Test Plan:
- Bench uses SAMPLE_CYCLES=20.
- Reset: after rst_n rises, outputs are 0 and cmd_ready=1. Drive rst_n low mid-RUN → motor_en=0 immediately, FSM in IDLE.
- Speed: hold pos1=7 steady → every 20 cycles speed=7, speed_valid=1 and clear[0]=1 (one cycle each, consecutive). No clear[1].
- Move: cmd_dist=10 accepted, pos2 ramps 0→12 → subtract=1 with distance=10 exactly once when pos2≥10. move_done follows 2 cycles later; motor_en is low after.
- Collision: arrange the SUB state to coincide with the clear[0] cycle → subtract is delayed exactly one cycle and is never asserted alongside clear.
- Zero/abort:
  - cmd_dist=0 → move_done next cycle, no subtract, motor_en never high.
  - abort during RUN with cmd_dist=50 → clear=2'b10 for one cycle, no move_done, cmd_ready=1.
- SPEED_AVG_EN: samples 4,8,12,16 → speed 1,3,6,10.
